gpio_bank_arbiter: RTL and testbench
====================================

Name: gpio_bank_arbiter

Overview:
- Shares one single-port GPIO register bank (16 x 16-bit: direction, output and input words) between the GPMC host path and N internal clients, such as the input sampler and future PWM or event blocks.
- Sits between gpmc_sync and the register-bank RAM.
- Serialises all accesses: host has fixed priority; clients are served round-robin with a req/ack handshake.

Parameters:
ADDR_WIDTH, 4, register-bank address width
DATA_WIDTH, 16, register word width
N_CLIENTS, 2, number of internal clients (1..4)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
host_cs_n  in  1  host chip select from gpmc_sync, active low
host_we_n  in  1  host write strobe, active low
host_oe_n  in  1  host read strobe, active low
host_addr  in  ADDR_WIDTH  host word address
host_wdata  in  DATA_WIDTH  host write data
host_rdata  out  DATA_WIDTH  host read data to gpmc_sync
cl_req  in  N_CLIENTS  per-client request
cl_we  in  N_CLIENTS  per-client write (1) / read (0)
cl_addr  in  N_CLIENTS*ADDR_WIDTH  packed client addresses, client i at [i*AW +: AW]
cl_wdata  in  N_CLIENTS*DATA_WIDTH  packed client write data
cl_ack  out  N_CLIENTS  one-cycle completion pulse per client
cl_rdata  out  DATA_WIDTH  shared client read data, valid only with cl_ack
mem_en  out  1  RAM access enable
mem_we  out  1  RAM write enable
mem_addr  out  ADDR_WIDTH  RAM address
mem_wdata  out  DATA_WIDTH  RAM write data
mem_rdata  in  DATA_WIDTH  RAM read data, one cycle after mem_en (synchronous RAM)

Behaviour:
- Reset:
  - Async assert: all outputs 0; FSM to IDLE; host pending flag clear; round-robin pointer 0.
  - An in-flight access is abandoned and no ack is issued.
- Host request detection:
  - Host write = cs_n=0, we_n=0, oe_n=1. Host read = cs_n=0, we_n=1, oe_n=0.
  - Both strobes low, or cs_n high: no request.
  - Each strobe assertion is detected on its first cycle (edge versus the registered previous value) and sets host_pend. Exactly one access per assertion, however long the strobe is held.
  - Write address and data are captured at detection.
- FSM states: IDLE, ISSUE, RDWAIT.
  - IDLE:
    - If host_pend: grant host.
    - Else if any cl_req: grant the first requester at or after rr_ptr, wrapping modulo N_CLIENTS.
    - On a grant, register mem_en=1, mem_we, mem_addr and mem_wdata, then go to ISSUE.
  - ISSUE:
    - mem_en deasserts.
    - Write: client winner gets cl_ack=1 this cycle; go to IDLE.
    - Read: go to RDWAIT.
  - RDWAIT:
    - Capture mem_rdata.
    - Client winner: cl_rdata=mem_rdata and cl_ack=1 this cycle.
    - Host winner: host_rdata=mem_rdata only if the read strobe is still asserted; otherwise the result is dropped. Go to IDLE.
- Latency:
  - Write: grant to ack = 1 cycle.
  - Read: grant to data = 2 cycles.
  - Throughput: one write per 2 cycles, one read per 3 cycles.
- Round-robin: after each client grant, rr_ptr = winner+1 mod N_CLIENTS. Host grants do not move rr_ptr.
- host_rdata holds its value while the read strobe stays asserted and returns to 0 the cycle after oe_n or cs_n deasserts.
- host_pend clears when the host is granted. A new strobe edge arriving while the host access is in flight sets host_pend again.
- Client protocol:
  - cl_req, cl_we, cl_addr and cl_wdata must stay stable from assertion until cl_ack.
  - Deasserting before ack is a protocol violation; the arbiter may still complete the access.
  - The same client may re-request the cycle after its ack.
- Simultaneous host edge and client request in IDLE: host wins; the client waits at most one host access.
- cl_ack is one-hot or zero at all times.

Decomposition:
- Shared package gpio_bank_pkg:
  - ADDR_WIDTH and DATA_WIDTH defaults
  - FSM state encoding
  - register map constants: DIR0..2 = 0..2, IN0..2 = 3..5, OUT0..2 = 6..8
- One sub-module, rr_arbiter: N-way round-robin picker.
  - Inputs: req vector, rr_ptr.
  - Outputs: one-hot grant and winner index.
  - Purely combinational; rr_ptr is held in the parent.

Test Plan:
- Host write: addr 6, data 0x00A5, strobe held 4 cycles -> exactly one mem_en pulse with mem_we=1, addr 6, data 0x00A5.
- Host read: preload addr 3 = 0x1234 -> host_rdata = 0x1234 two cycles after strobe detection; returns to 0 one cycle after oe_n rises.
- Client fairness: both clients hold read requests continuously -> acks alternate 0,1,0,1; each ack's cl_rdata matches its own addressed word.
- Host priority: host write edge in the same cycle client 1 requests -> host mem access first; client 1 acked 2 cycles later.
- Early host deassert: host read strobe drops after 1 cycle -> RAM is still read, host_rdata stays 0, no client ack is affected.
- Reset mid-read: rst_n asserted in RDWAIT -> all outputs 0 immediately, no ack; first client grant after release goes to client 0.

Source files
------------

// File: rtl/gpio_bank_pkg.sv
// rtl/gpio_bank_pkg.sv - shared widths, FSM encoding and register map for the GPIO bank arbiter
package gpio_bank_pkg;

  localparam int ADDR_WIDTH_DEF = 4;
  localparam int DATA_WIDTH_DEF = 16;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ISSUE  = 2'd1;
  localparam logic [1:0] ST_RDWAIT = 2'd2;

  localparam logic [3:0] REG_DIR0 = 4'd0;
  localparam logic [3:0] REG_DIR1 = 4'd1;
  localparam logic [3:0] REG_DIR2 = 4'd2;
  localparam logic [3:0] REG_IN0  = 4'd3;
  localparam logic [3:0] REG_IN1  = 4'd4;
  localparam logic [3:0] REG_IN2  = 4'd5;
  localparam logic [3:0] REG_OUT0 = 4'd6;
  localparam logic [3:0] REG_OUT1 = 4'd7;
  localparam logic [3:0] REG_OUT2 = 4'd8;

  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin picker: first requester at or after ptr
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] winner,
  output logic          found
);

  int idx;

  // Scan from farthest to nearest so the nearest requester overwrites the result.
  always_comb begin
    grant  = '0;
    winner = '0;
    found  = |req;
    idx    = 0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (req[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
        winner     = idx[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/gpio_bank_arbiter.sv
// rtl/gpio_bank_arbiter.sv - serialises host and client accesses to the single-port GPIO register bank
module gpio_bank_arbiter
  import gpio_bank_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int N_CLIENTS  = 2
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             host_cs_n,
  input  logic                             host_we_n,
  input  logic                             host_oe_n,
  input  logic [ADDR_WIDTH-1:0]            host_addr,
  input  logic [DATA_WIDTH-1:0]            host_wdata,
  output logic [DATA_WIDTH-1:0]            host_rdata,
  input  logic [N_CLIENTS-1:0]             cl_req,
  input  logic [N_CLIENTS-1:0]             cl_we,
  input  logic [N_CLIENTS*ADDR_WIDTH-1:0]  cl_addr,
  input  logic [N_CLIENTS*DATA_WIDTH-1:0]  cl_wdata,
  output logic [N_CLIENTS-1:0]             cl_ack,
  output logic [DATA_WIDTH-1:0]            cl_rdata,
  output logic                             mem_en,
  output logic                             mem_we,
  output logic [ADDR_WIDTH-1:0]            mem_addr,
  output logic [DATA_WIDTH-1:0]            mem_wdata,
  input  logic [DATA_WIDTH-1:0]            mem_rdata
);

  localparam int IW = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;

  logic                  host_wr, host_rd, wr_q, rd_q, host_edge;
  logic                  host_pend, hq_we;
  logic [ADDR_WIDTH-1:0] hq_addr;
  logic [DATA_WIDTH-1:0] hq_wdata;
  logic [1:0]            state;
  logic                  win_host, win_we;
  logic [N_CLIENTS-1:0]  win_grant, req_live, pick_grant;
  logic [IW-1:0]         rr_ptr, pick;
  logic                  pick_found;

  assign host_wr   = ~host_cs_n & ~host_we_n &  host_oe_n;
  assign host_rd   = ~host_cs_n &  host_we_n & ~host_oe_n;
  assign host_edge = (host_wr & ~wr_q) | (host_rd & ~rd_q);

  // A client seeing its ack this cycle still holds req; masking it avoids a duplicate grant.
  assign req_live = cl_req & ~cl_ack;

  rr_arbiter #(.N(N_CLIENTS), .IW(IW)) u_rr (
    .req    (req_live),
    .ptr    (rr_ptr),
    .grant  (pick_grant),
    .winner (pick),
    .found  (pick_found)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q       <= 1'b0;
      rd_q       <= 1'b0;
      host_pend  <= 1'b0;
      hq_we      <= 1'b0;
      hq_addr    <= '0;
      hq_wdata   <= '0;
      state      <= ST_IDLE;
      win_host   <= 1'b0;
      win_we     <= 1'b0;
      win_grant  <= '0;
      rr_ptr     <= '0;
      host_rdata <= '0;
      cl_ack     <= '0;
      cl_rdata   <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      wr_q   <= host_wr;
      rd_q   <= host_rd;
      cl_ack <= '0;
      if (!host_rd) host_rdata <= '0;
      if (host_edge) begin
        host_pend <= 1'b1;
        hq_we     <= host_wr;
        hq_addr   <= host_addr;
        hq_wdata  <= host_wdata;
      end
      case (state)
        ST_IDLE: begin
          if (host_pend || host_edge) begin
            // A fresh edge alongside an older pending access stays pending for the next slot.
            host_pend <= host_pend & host_edge;
            mem_en    <= 1'b1;
            mem_we    <= host_pend ? hq_we    : host_wr;
            mem_addr  <= host_pend ? hq_addr  : host_addr;
            mem_wdata <= host_pend ? hq_wdata : host_wdata;
            win_host  <= 1'b1;
            win_we    <= host_pend ? hq_we    : host_wr;
            state     <= ST_ISSUE;
          end else if (pick_found) begin
            mem_en    <= 1'b1;
            mem_we    <= cl_we[pick];
            mem_addr  <= cl_addr[int'(pick)*ADDR_WIDTH +: ADDR_WIDTH];
            mem_wdata <= cl_wdata[int'(pick)*DATA_WIDTH +: DATA_WIDTH];
            win_host  <= 1'b0;
            win_we    <= cl_we[pick];
            win_grant <= pick_grant;
            rr_ptr    <= IW'(rr_next(int'(pick), N_CLIENTS));
            state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          mem_en <= 1'b0;
          mem_we <= 1'b0;
          if (win_we) begin
            if (!win_host) cl_ack <= win_grant;
            state <= ST_IDLE;
          end else begin
            state <= ST_RDWAIT;
          end
        end
        ST_RDWAIT: begin
          if (win_host) begin
            if (host_rd) host_rdata <= mem_rdata;
          end else begin
            cl_rdata <= mem_rdata;
            cl_ack   <= win_grant;
          end
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gpio_bank_arbiter.sv
// tb/tb_gpio_bank_arbiter.sv - directed and randomized bench for gpio_bank_arbiter with RAM and scoreboard
module tb_gpio_bank_arbiter;

  logic        clk;
  logic        rst_n;
  logic        host_cs_n, host_we_n, host_oe_n;
  logic [3:0]  host_addr;
  logic [15:0] host_wdata, host_rdata;
  logic [1:0]  cl_req, cl_we, cl_ack;
  logic [7:0]  cl_addr;
  logic [31:0] cl_wdata;
  logic [15:0] cl_rdata;
  logic        mem_en, mem_we;
  logic [3:0]  mem_addr;
  logic [15:0] mem_wdata, mem_rdata;

  logic        pre_en;
  logic [3:0]  pre_addr;
  logic [15:0] pre_data;
  logic [15:0] ram [16];

  logic [15:0] ref_mem [16];
  logic [20:0] mon_q [$];
  int          mon_cyc [$];
  int          cyc;
  int          exp_ptr;
  int          n_tests, n_fail;

  gpio_bank_arbiter #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .N_CLIENTS(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .host_cs_n(host_cs_n), .host_we_n(host_we_n), .host_oe_n(host_oe_n),
    .host_addr(host_addr), .host_wdata(host_wdata), .host_rdata(host_rdata),
    .cl_req(cl_req), .cl_we(cl_we), .cl_addr(cl_addr), .cl_wdata(cl_wdata),
    .cl_ack(cl_ack), .cl_rdata(cl_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pre_en) ram[pre_addr] <= pre_data;
    else if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish, expected finish before 1ms");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    if (mem_en) begin
      mon_q.push_back({mem_we, mem_addr, mem_wdata});
      mon_cyc.push_back(cyc);
    end
  endtask

  task automatic host_idle();
    host_cs_n = 1'b1; host_we_n = 1'b1; host_oe_n = 1'b1;
  endtask

  task automatic host_write(input logic [3:0] a, input logic [15:0] d, input int hold);
    host_cs_n = 1'b0; host_we_n = 1'b0; host_oe_n = 1'b1;
    host_addr = a; host_wdata = d;
    for (int k = 0; k < hold; k++) tick();
    host_idle();
    for (int k = 0; k < 3; k++) tick();
    ref_mem[a] = d;
  endtask

  task automatic host_read_start(input logic [3:0] a);
    host_cs_n = 1'b0; host_we_n = 1'b1; host_oe_n = 1'b0;
    host_addr = a; host_wdata = '0;
  endtask

  task automatic client_start(input int c, input logic we, input logic [3:0] a, input logic [15:0] d);
    cl_req[c] = 1'b1; cl_we[c] = we;
    cl_addr[c*4 +: 4] = a; cl_wdata[c*16 +: 16] = d;
  endtask

  task automatic wait_ack(output logic [1:0] ack, output logic [15:0] rd);
    ack = '0; rd = '0;
    for (int k = 0; k < 20 && ack == 2'b00; k++) begin
      tick();
      ack = cl_ack;
      rd  = cl_rdata;
    end
  endtask

  logic [1:0]  ack;
  logic [15:0] rd, acc, hd, cd;
  int          last_cyc;
  logic        act [2];
  logic        op_we [2];
  logic [3:0]  op_addr [2];
  logic [15:0] op_data [2];
  int          waits [2];
  int          start [2];

  initial begin
    n_tests = 0; n_fail = 0; cyc = 0; exp_ptr = 0;
    rst_n = 1'b0; host_idle(); host_addr = '0; host_wdata = '0;
    cl_req = '0; cl_we = '0; cl_addr = '0; cl_wdata = '0;
    pre_en = 1'b0; pre_addr = '0; pre_data = '0;

    // Preload the RAM with distinct words while the arbiter is held in reset.
    for (int i = 0; i < 16; i++) begin
      pre_en = 1'b1; pre_addr = 4'(i); pre_data = {4'(i), 12'($urandom)};
      ref_mem[i] = pre_data;
      tick();
    end
    pre_en = 1'b0;
    tick();
    chk("reset_mem_outs", {10'd0, mem_en, mem_we, mem_addr, mem_wdata}, 32'd0);
    chk("reset_rdata", {host_rdata, cl_rdata}, 32'd0);
    chk("reset_ack", {30'd0, cl_ack}, 32'd0);
    rst_n = 1'b1;
    tick(); tick();

    // Host write with the strobe held for four cycles.
    mon_q.delete(); mon_cyc.delete();
    host_write(4'd6, 16'h00A5, 4);
    chk("hw_pulses", mon_q.size(), 1);
    chk("hw_access", {11'd0, mon_q[0]}, {11'd0, 1'b1, 4'd6, 16'h00A5});

    // Host read of addr 3: data two cycles after the grant, cleared after oe_n rises.
    host_write(4'd3, 16'h1234, 1);
    host_read_start(4'd3);
    tick();
    chk("hr_grant_en", {31'd0, mem_en}, 32'd1);
    tick();
    chk("hr_early", {16'd0, host_rdata}, 32'd0);
    tick();
    chk("hr_data", {16'd0, host_rdata}, {16'd0, 16'h1234});
    tick(); tick();
    chk("hr_hold", {16'd0, host_rdata}, {16'd0, 16'h1234});
    host_idle();
    tick();
    chk("hr_clear", {16'd0, host_rdata}, 32'd0);
    tick();

    // Early host deassert with a simultaneous client 0 read.
    mon_q.delete(); mon_cyc.delete();
    host_read_start(4'd4);
    client_start(0, 1'b0, 4'd5, 16'h0);
    tick();
    host_idle();
    acc = '0;
    for (int k = 0; k < 4; k++) begin tick(); acc = acc | host_rdata; end
    chk("early_host_rdata", {16'd0, acc}, 32'd0);
    wait_ack(ack, rd);
    cl_req[0] = 1'b0;
    chk("early_cl_ack", {30'd0, ack}, 32'd1);
    chk("early_cl_rdata", {16'd0, rd}, {16'd0, ref_mem[5]});
    chk("early_accesses", mon_q.size(), 2);
    chk("early_host_read", {27'd0, mon_q[0][20:16]}, {27'd0, 1'b0, 4'd4});
    exp_ptr = 1;

    // Host write edge in the same cycle client 1 requests a write.
    tick();
    mon_q.delete(); mon_cyc.delete();
    hd = 16'($urandom); cd = 16'($urandom);
    host_cs_n = 1'b0; host_we_n = 1'b0; host_oe_n = 1'b1; host_addr = 4'd7; host_wdata = hd;
    client_start(1, 1'b1, 4'd8, cd);
    tick();
    host_idle();
    wait_ack(ack, rd);
    cl_req[1] = 1'b0;
    ref_mem[7] = hd; ref_mem[8] = cd;
    chk("prio_ack", {30'd0, ack}, 32'd2);
    chk("prio_first", {11'd0, mon_q[0]}, {11'd0, 1'b1, 4'd7, hd});
    chk("prio_second", {11'd0, mon_q[1]}, {11'd0, 1'b1, 4'd8, cd});
    chk("prio_gap", mon_cyc[1] - mon_cyc[0], 2);
    exp_ptr = 0;

    // Both clients hold read requests: acks alternate, three cycles apart.
    tick();
    client_start(0, 1'b0, 4'd0, 16'h0);
    client_start(1, 1'b0, 4'd1, 16'h0);
    last_cyc = 0;
    for (int k = 0; k < 6; k++) begin
      wait_ack(ack, rd);
      chk("fair_ack", {30'd0, ack}, 32'(1 << exp_ptr));
      chk("fair_rdata", {16'd0, rd}, {16'd0, ref_mem[exp_ptr]});
      if (k > 0) chk("fair_spacing", cyc - last_cyc, 3);
      last_cyc = cyc;
      if (k >= 4) cl_req[exp_ptr] = 1'b0;
      exp_ptr = (exp_ptr + 1) % 2;
    end

    // Reset while a client 0 read sits in RDWAIT; pointer must restart at client 0.
    tick();
    client_start(0, 1'b0, 4'd2, 16'h0);
    tick(); tick();
    rst_n = 1'b0;
    #1;
    chk("rstmid_mem_outs", {10'd0, mem_en, mem_we, mem_addr, mem_wdata}, 32'd0);
    chk("rstmid_rdata", {host_rdata, cl_rdata}, 32'd0);
    cl_req = '0;
    tick();
    chk("rstmid_no_ack", {30'd0, cl_ack}, 32'd0);
    tick();
    rst_n = 1'b1;
    exp_ptr = 0;
    tick();
    hd = 16'($urandom); cd = 16'($urandom);
    client_start(0, 1'b1, 4'd9, hd);
    client_start(1, 1'b1, 4'd10, cd);
    wait_ack(ack, rd);
    cl_req[0] = 1'b0;
    chk("rstmid_first", {30'd0, ack}, 32'd1);
    wait_ack(ack, rd);
    cl_req[1] = 1'b0;
    chk("rstmid_second", {30'd0, ack}, 32'd2);
    ref_mem[9] = hd; ref_mem[10] = cd;
    tick();

    // Randomized client traffic against the shadow memory and fairness bound.
    for (int i = 0; i < 2; i++) begin act[i] = 1'b0; waits[i] = 0; start[i] = 0; end
    for (int t = 0; t < 450; t++) begin
      tick();
      if (cl_ack != 2'b00) begin
        chk("rnd_onehot", $countones(cl_ack), 1);
        for (int i = 0; i < 2; i++) begin
          if (cl_ack[i]) begin
            chk("rnd_ack_owner", {31'd0, act[i]}, 32'd1);
            if (act[i]) begin
              if (!op_we[i]) chk("rnd_rdata", {16'd0, cl_rdata}, {16'd0, ref_mem[op_addr[i]]});
              else ref_mem[op_addr[i]] = op_data[i];
              chk("rnd_wait_bound", {31'd0, waits[i] <= 1}, 32'd1);
              chk("rnd_latency", {31'd0, (cyc - start[i]) <= 10}, 32'd1);
              for (int j = 0; j < 2; j++) if (j != i && act[j]) waits[j]++;
              act[i] = 1'b0;
              cl_req[i] = 1'b0;
            end
          end
        end
      end
      for (int i = 0; i < 2; i++) begin
        if (act[i] && (cyc - start[i]) > 40) begin
          chk("rnd_timeout_cycles", cyc - start[i], 40);
          act[i] = 1'b0;
          cl_req[i] = 1'b0;
        end
      end
      if (t < 400) begin
        for (int i = 0; i < 2; i++) begin
          if (!act[i] && $urandom_range(2) == 0) begin
            act[i] = 1'b1; waits[i] = 0; start[i] = cyc;
            op_we[i] = 1'($urandom_range(1)); op_addr[i] = 4'($urandom);
            op_data[i] = 16'($urandom);
            client_start(i, op_we[i], op_addr[i], op_data[i]);
          end
        end
      end
    end
    chk("rnd_drained", {30'd0, act[1], act[0]}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
